// File: rtl/param_stack_if.sv
// Push/pop bus between the control unit (master) and the parametrised LIFO (slave).
// Widths follow the stack's WIDTH/DEPTH so both ends agree on data and count sizes.
interface param_stack_if #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 32
);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic             push;
    logic             pop;
    logic [WIDTH-1:0] din;
    logic             err_clr;
    logic [WIDTH-1:0] dout;
    logic             dout_valid;
    logic [WIDTH-1:0] top;
    logic [CW-1:0]    count;
    logic             empty;
    logic             full;
    logic             overflow;
    logic             underflow;

    modport master (
        output push, pop, din, err_clr,
        input  dout, dout_valid, top, count, empty, full, overflow, underflow
    );

    modport slave (
        input  push, pop, din, err_clr,
        output dout, dout_valid, top, count, empty, full, overflow, underflow
    );
endinterface

// File: rtl/param_stack.sv
// Parametrised LIFO with replace-top, status flags and overflow/underflow reporting.
// Optional feature macro: STACK_STICKY_ERR_EN (sticky error flags cleared by err_clr).
module param_stack #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 32
) (
    input  logic         clk,
    input  logic         reset,
    param_stack_if.slave bus
);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [2:0] {
        OP_IDLE,
        OP_PUSH,
        OP_POP,
        OP_REPL,
        OP_PASS,
        OP_OVF,
        OP_UNF
    } op_e;

    logic [WIDTH-1:0] mem [DEPTH];

    logic [CW-1:0]    count_q, count_n;
    logic [WIDTH-1:0] dout_q, dout_n;
    logic             dv_q, dv_n;
    logic             ovf_q, ovf_n;
    logic             unf_q, unf_n;

    op_e              op_c;
    logic             empty_c;
    logic             full_c;
    logic [AW-1:0]    top_idx_c;
    logic [WIDTH-1:0] top_c;
    logic             wr_en_c;
    logic [AW-1:0]    wr_idx_c;
    logic             ovf_evt_c;
    logic             unf_evt_c;

    assign empty_c   = (count_q == CW'(0));
    assign full_c    = (count_q == CW'(DEPTH));
    assign top_idx_c = AW'(count_q - CW'(1));
    assign top_c     = empty_c ? '0 : mem[top_idx_c];

    // Decode the cycle's operation from the request pair and current occupancy.
    always_comb begin
        op_c = OP_IDLE;
        case ({bus.push, bus.pop})
            2'b10:   op_c = full_c  ? OP_OVF  : OP_PUSH;
            2'b01:   op_c = empty_c ? OP_UNF  : OP_POP;
            2'b11:   op_c = empty_c ? OP_PASS : OP_REPL;
            default: op_c = OP_IDLE;
        endcase
    end

    always_comb begin
        count_n   = count_q;
        dout_n    = dout_q;
        dv_n      = 1'b0;
        wr_en_c   = 1'b0;
        wr_idx_c  = AW'(count_q);
        ovf_evt_c = 1'b0;
        unf_evt_c = 1'b0;
        case (op_c)
            OP_PUSH: begin
                wr_en_c = 1'b1;
                count_n = count_q + CW'(1);
            end
            OP_POP: begin
                dout_n  = top_c;
                dv_n    = 1'b1;
                count_n = count_q - CW'(1);
            end
            OP_REPL: begin
                dout_n   = top_c;
                dv_n     = 1'b1;
                wr_en_c  = 1'b1;
                wr_idx_c = top_idx_c;
            end
            OP_PASS: begin
                dout_n = bus.din;
                dv_n   = 1'b1;
            end
            OP_OVF:  ovf_evt_c = 1'b1;
            OP_UNF:  unf_evt_c = 1'b1;
            default: ;
        endcase
`ifdef STACK_STICKY_ERR_EN
        // A fresh error in the same cycle takes precedence over the clear.
        ovf_n = ovf_evt_c | (ovf_q & ~bus.err_clr);
        unf_n = unf_evt_c | (unf_q & ~bus.err_clr);
`else
        ovf_n = ovf_evt_c;
        unf_n = unf_evt_c;
`endif
    end

`ifndef STACK_STICKY_ERR_EN
    logic unused_err_clr;
    assign unused_err_clr = bus.err_clr;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
            dout_q  <= '0;
            dv_q    <= 1'b0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            count_q <= count_n;
            dout_q  <= dout_n;
            dv_q    <= dv_n;
            ovf_q   <= ovf_n;
            unf_q   <= unf_n;
        end
    end

    // Storage needs no reset; a write coinciding with reset is discarded.
    always_ff @(posedge clk) begin
        if (wr_en_c && !reset) begin
            mem[wr_idx_c] <= bus.din;
        end
    end

    assign bus.dout       = dout_q;
    assign bus.dout_valid = dv_q;
    assign bus.top        = top_c;
    assign bus.count      = count_q;
    assign bus.empty      = empty_c;
    assign bus.full       = full_c;
    assign bus.overflow   = ovf_q;
    assign bus.underflow  = unf_q;
endmodule

// File: tb/tb_param_stack.sv
// Directed bench for param_stack (WIDTH=32, DEPTH=4) with hand-computed expectations.
// Builds with or without STACK_STICKY_ERR_EN; sticky expectations follow the macro.
module tb_param_stack;
    localparam int unsigned WIDTH = 32;
    localparam int unsigned DEPTH = 4;
`ifdef STACK_STICKY_ERR_EN
    localparam logic STICKY = 1'b1;
`else
    localparam logic STICKY = 1'b0;
`endif

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    param_stack_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    param_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Apply one cycle of stimulus, then sample 1 time unit after the edge.
    task automatic step(input logic p, input logic q, input logic [31:0] d, input logic clr);
        bus.push    = p;
        bus.pop     = q;
        bus.din     = d;
        bus.err_clr = clr;
        @(posedge clk);
        #1;
        bus.push    = 1'b0;
        bus.pop     = 1'b0;
        bus.err_clr = 1'b0;
    endtask

    task automatic check_flags(input string tag, input logic ovf, input logic unf);
        check({tag, ".overflow"},  32'(bus.overflow),  32'(ovf));
        check({tag, ".underflow"}, 32'(bus.underflow), 32'(unf));
    endtask

    initial begin
        checks      = 0;
        failures    = 0;
        reset       = 1'b1;
        bus.push    = 1'b0;
        bus.pop     = 1'b0;
        bus.din     = '0;
        bus.err_clr = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        reset = 1'b0;

        check("rst.count", 32'(bus.count), 32'd0);
        check("rst.empty", 32'(bus.empty), 32'd1);
        check("rst.full",  32'(bus.full),  32'd0);
        check("rst.top",   bus.top,        32'h0);
        check("rst.dout",  bus.dout,       32'h0);
        check("rst.dv",    32'(bus.dout_valid), 32'd0);
        check_flags("rst", 1'b0, 1'b0);

        // Push three, pop three: LIFO order with one-cycle latency.
        step(1'b1, 1'b0, 32'h11, 1'b0);
        check("p1.top",   bus.top,        32'h11);
        check("p1.count", 32'(bus.count), 32'd1);
        check("p1.empty", 32'(bus.empty), 32'd0);
        step(1'b1, 1'b0, 32'h22, 1'b0);
        step(1'b1, 1'b0, 32'h33, 1'b0);
        check("p3.count", 32'(bus.count), 32'd3);
        check("p3.top",   bus.top,        32'h33);
        step(1'b0, 1'b1, 32'h0, 1'b0);
        check("pop1.dout",  bus.dout,       32'h33);
        check("pop1.dv",    32'(bus.dout_valid), 32'd1);
        check("pop1.count", 32'(bus.count), 32'd2);
        step(1'b0, 1'b1, 32'h0, 1'b0);
        check("pop2.dout",  bus.dout,       32'h22);
        check("pop2.dv",    32'(bus.dout_valid), 32'd1);
        step(1'b0, 1'b1, 32'h0, 1'b0);
        check("pop3.dout",  bus.dout,       32'h11);
        check("pop3.dv",    32'(bus.dout_valid), 32'd1);
        check("pop3.count", 32'(bus.count), 32'd0);
        check("pop3.empty", 32'(bus.empty), 32'd1);
        check("pop3.top",   bus.top,        32'h0);
        step(1'b0, 1'b0, 32'h0, 1'b0);
        check("idle.dv",   32'(bus.dout_valid), 32'd0);
        check("idle.dout", bus.dout,       32'h11);

        // Pop while empty.
        step(1'b0, 1'b1, 32'h0, 1'b0);
        check_flags("unf", 1'b0, 1'b1);
        check("unf.dv",    32'(bus.dout_valid), 32'd0);
        check("unf.dout",  bus.dout,       32'h11);
        check("unf.count", 32'(bus.count), 32'd0);
        step(1'b0, 1'b0, 32'h0, 1'b0);
        check_flags("unf_hold", 1'b0, STICKY);
        step(1'b0, 1'b0, 32'h0, 1'b1);
        check_flags("unf_clr", 1'b0, 1'b0);

        // Push+pop on empty passes din straight through.
        step(1'b1, 1'b1, 32'h77, 1'b0);
        check("pass.dout",  bus.dout,       32'h77);
        check("pass.dv",    32'(bus.dout_valid), 32'd1);
        check("pass.count", 32'(bus.count), 32'd0);
        check("pass.empty", 32'(bus.empty), 32'd1);
        check_flags("pass", 1'b0, 1'b0);

        // Fill to DEPTH, then overflow.
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b0, 32'hA0 + 32'(i), 1'b0);
        end
        check("fill.full",  32'(bus.full),  32'd1);
        check("fill.count", 32'(bus.count), 32'd4);
        check("fill.top",   bus.top,        32'hA3);
        check_flags("fill", 1'b0, 1'b0);
        step(1'b1, 1'b0, 32'hA4, 1'b0);
        check_flags("ovf", 1'b1, 1'b0);
        check("ovf.count", 32'(bus.count), 32'd4);
        check("ovf.top",   bus.top,        32'hA3);
        check("ovf.dv",    32'(bus.dout_valid), 32'd0);
        step(1'b0, 1'b0, 32'h0, 1'b0);
        check_flags("ovf_hold", STICKY, 1'b0);
        // New overflow in the same cycle as err_clr must still be flagged.
        step(1'b1, 1'b0, 32'hA5, 1'b1);
        check_flags("ovf_vs_clr", 1'b1, 1'b0);
        step(1'b0, 1'b0, 32'h0, 1'b1);
        check_flags("ovf_clr", 1'b0, 1'b0);

        // Replace-top while full.
        step(1'b1, 1'b1, 32'h5, 1'b0);
        check("rfull.dout",  bus.dout,       32'hA3);
        check("rfull.top",   bus.top,        32'h5);
        check("rfull.count", 32'(bus.count), 32'd4);
        check_flags("rfull", 1'b0, 1'b0);

        // Drain: 0x5, 0xA2, 0xA1, 0xA0.
        step(1'b0, 1'b1, 32'h0, 1'b0);
        check("drain1.dout", bus.dout, 32'h5);
        step(1'b0, 1'b1, 32'h0, 1'b0);
        check("drain2.dout", bus.dout, 32'hA2);
        step(1'b0, 1'b1, 32'h0, 1'b0);
        step(1'b0, 1'b1, 32'h0, 1'b0);
        check("drain4.dout",  bus.dout,       32'hA0);
        check("drain4.empty", 32'(bus.empty), 32'd1);

        // Stack {0x1,0x2}, replace-top with 0x9.
        step(1'b1, 1'b0, 32'h1, 1'b0);
        step(1'b1, 1'b0, 32'h2, 1'b0);
        step(1'b1, 1'b1, 32'h9, 1'b0);
        check("repl.dout",  bus.dout,       32'h2);
        check("repl.top",   bus.top,        32'h9);
        check("repl.count", 32'(bus.count), 32'd2);
        check("repl.dv",    32'(bus.dout_valid), 32'd1);
        check_flags("repl", 1'b0, 1'b0);
        step(1'b0, 1'b1, 32'h0, 1'b0);
        check("repl_pop.dout", bus.dout, 32'h9);
        check("repl_pop.top",  bus.top,  32'h1);

        // Reset with a push in flight empties the stack.
        step(1'b1, 1'b0, 32'h5, 1'b0);
        check("prerst.count", 32'(bus.count), 32'd2);
        reset = 1'b1;
        step(1'b1, 1'b0, 32'h6, 1'b0);
        reset = 1'b0;
        check("rst2.count", 32'(bus.count), 32'd0);
        check("rst2.empty", 32'(bus.empty), 32'd1);
        check("rst2.top",   bus.top,        32'h0);
        check("rst2.dout",  bus.dout,       32'h0);
        check("rst2.dv",    32'(bus.dout_valid), 32'd0);
        check_flags("rst2", 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
